// File: rtl/code_link_pkg.sv
// Shared definitions for the pushbutton code link (TX encoder and RX receiver).
package code_link_pkg;

  localparam int unsigned CODE_W         = 8;
  localparam int unsigned KEY_W          = 4;
  localparam int unsigned HDR_W          = CODE_W - KEY_W;
  localparam logic [HDR_W-1:0] HEADER    = 4'b1010;
  localparam int unsigned DEF_BIT_CYCLES = 12500;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // True when the upper nibble of a frame window carries the link header.
  function automatic logic header_ok(input logic [CODE_W-1:0] w);
    return w[CODE_W-1 -: HDR_W] == HEADER;
  endfunction

endpackage

// File: rtl/bit_sampler.sv
// Bit timing recovery: 2-flop synchronizer, edge detector and phase counter
// that strobes mid-bit. Optional edge output under CODE_RX_TIMEOUT_EN.
module bit_sampler
  import code_link_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serial_in,
  output logic bit_val,
  output logic bit_stb
`ifdef CODE_RX_TIMEOUT_EN
  ,
  output logic bit_edge
`endif
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] phase_cnt;
  logic             edge_c;
  logic             expire_c;

  assign edge_c   = sync2 ^ prev;
  assign expire_c = (phase_cnt == '0);

  // Synchronize the asynchronous line and keep the previous value for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Phase counter: an edge re-centres the strobe half a bit later; an edge wins over expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      bit_stb   <= 1'b0;
      bit_val   <= 1'b0;
    end else begin
      if (edge_c) begin
        phase_cnt <= HALF_LOAD;
      end else if (expire_c) begin
        phase_cnt <= FULL_LOAD;
      end else begin
        phase_cnt <= phase_cnt - CNT_W'(1);
      end
      bit_stb <= expire_c & ~edge_c;
      bit_val <= sync2;
    end
  end

`ifdef CODE_RX_TIMEOUT_EN
  // Registered edge indication feeding the idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_edge <= 1'b0;
    end else begin
      bit_edge <= edge_c;
    end
  end
`endif

endmodule

// File: rtl/code_receiver.sv
// Receive end of the pushbutton code link: frame alignment, consistency
// check and registered code/button outputs. Optional idle timeout is
// enabled with the CODE_RX_TIMEOUT_EN macro.
module code_receiver
  import code_link_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = DEF_BIT_CYCLES,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  output logic [CODE_W-1:0] code,
  output logic [KEY_W-1:0]  buttons,
  output logic              locked,
  output logic              frame_stb
);

  logic              bit_val;
  logic              bit_stb;
  rx_state_t         state;
  rx_state_t         state_d;
  logic [CODE_W-1:0] window;
  logic [CODE_W-1:0] win_next;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_d;
  logic [2:0]        match_cnt;
  logic [2:0]        match_d;
  logic [2:0]        match_inc;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_cnt_d;
  logic [CODE_W-1:0] code_d;
  logic              stb_d;
  logic              check_c;

`ifdef CODE_RX_TIMEOUT_EN
  localparam int unsigned IDLE_CYCLES = 16 * BIT_CYCLES;
  localparam int unsigned IDLE_W      = $clog2(IDLE_CYCLES + 1);

  logic              bit_edge;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_c;

  assign timeout_c = (idle_cnt == IDLE_W'(IDLE_CYCLES));

  // Idle timer: cleared by every edge, saturates at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (bit_edge) begin
      idle_cnt <= '0;
    end else if (!timeout_c) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`endif

  bit_sampler #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .serial_in(serial_in),
    .bit_val  (bit_val),
    .bit_stb  (bit_stb)
`ifdef CODE_RX_TIMEOUT_EN
    ,
    .bit_edge (bit_edge)
`endif
  );

  assign win_next  = {window[CODE_W-2:0], bit_val};
  assign match_inc = match_cnt + 3'd1;
  assign check_c   = bit_stb && (bit_cnt == 3'd7);

  // State, window and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      window    <= '0;
      cand      <= '0;
      match_cnt <= '0;
      bit_cnt   <= '0;
      code      <= '0;
      buttons   <= '0;
      locked    <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      state     <= state_d;
      if (bit_stb) begin
        window <= win_next;
      end
      cand      <= cand_d;
      match_cnt <= match_d;
      bit_cnt   <= bit_cnt_d;
      code      <= code_d;
      buttons   <= (state_d == LOCKED) ? code_d[KEY_W-1:0] : '0;
      locked    <= (state_d == LOCKED);
      frame_stb <= stb_d;
    end
  end

  // Alignment FSM: hunt for a header, confirm repeated frames, then track.
  always_comb begin
    state_d   = state;
    cand_d    = cand;
    match_d   = match_cnt;
    bit_cnt_d = bit_cnt;
    code_d    = code;
    stb_d     = 1'b0;

    if (bit_stb && (state != HUNT)) begin
      bit_cnt_d = bit_cnt + 3'd1;
    end

    case (state)
      HUNT: begin
        if (bit_stb && header_ok(win_next)) begin
          state_d   = VERIFY;
          cand_d    = win_next;
          match_d   = 3'd1;
          bit_cnt_d = '0;
        end
      end
      VERIFY: begin
        if (check_c) begin
          if (!header_ok(win_next)) begin
            state_d = HUNT;
          end else if (win_next != cand) begin
            cand_d  = win_next;
            match_d = 3'd1;
          end else begin
            match_d = match_inc;
            if (match_inc >= 3'(LOCK_FRAMES)) begin
              state_d = LOCKED;
              code_d  = win_next;
              stb_d   = 1'b1;
            end
          end
        end
      end
      LOCKED: begin
        if (check_c) begin
          if (header_ok(win_next)) begin
            code_d = win_next;
            stb_d  = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

`ifdef CODE_RX_TIMEOUT_EN
    if (timeout_c) begin
      state_d = HUNT;
      code_d  = code;
      stb_d   = 1'b0;
    end
`endif
  end

endmodule

// File: doc/code_receiver.md
# code_receiver

Receive end of the pushbutton code link. It recovers bit timing from the 4 kHz NRZ serial stream produced by the transmitter board's code shifter, finds frame alignment, and checks frame consistency. It then outputs the decoded 8-bit code and the 4 button states. It sits on the RX board between the GPIO input pin and the display/decode logic, and runs entirely on the 50 MHz board clock.

## Interface
- `BIT_CYCLES`, 12500: clock cycles per serial bit (50 MHz / 4 kHz); must be even and ≥ 8.
- `LOCK_FRAMES`, 2: consecutive identical valid frames required to acquire lock (1..7).
- `clk` input 1: 50 MHz clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `serial_in` input 1: raw serial line from GPIO, asynchronous to `clk`, MSB first.
- `code` output 8: last accepted frame.
- `buttons` output 4: `code[3:0]`, 1 = pressed; forced 0 when unlocked.
- `locked` output 1: frame alignment held.
- `frame_stb` output 1: one-cycle pulse per accepted frame.

## Operation
- Frame: 8 bits, MSB first, back-to-back with no gaps; `[7:4]` is the header `4'b1010`, `[3:0]` is button data.
- Input path: 2-flop synchronizer, then an edge detector comparing against the previous synchronized value.
- Phase counter:
  - A detected edge loads the counter so a sample strobe fires `BIT_CYCLES/2` cycles later.
  - With no edge, strobes repeat every `BIT_CYCLES` cycles.
  - An edge in the same cycle as counter expiry wins: reload, no strobe that cycle.
- Each strobe shifts the synchronized bit into an 8-bit window (new bit enters at `[0]`).
- FSM states `HUNT`, `VERIFY`, `LOCKED`; `bit_cnt` is 3 bits and wraps 7→0.
  - `HUNT`: on a strobe where `window[7:4]==HEADER`, go to `VERIFY`: `cand<=window`, `match_cnt<=1`, `bit_cnt<=0`.
  - `VERIFY`: a frame check happens on the strobe where `bit_cnt` wraps 7→0 (8 strobes after the previous check).
    - Header mismatch → `HUNT`.
    - Header ok and `window!=cand` → `cand<=window`, `match_cnt<=1`.
    - Header ok and `window==cand` → `match_cnt+1`. On reaching `LOCK_FRAMES`, go to `LOCKED`, load `code`, pulse `frame_stb`.
  - `LOCKED`: frame check every 8 strobes.
    - Header ok → load `code`, pulse `frame_stb` (even if the value is unchanged).
    - Header mismatch → `HUNT`, `locked<=0`, `buttons` forced 0; `code` holds its last value.
- `locked` is 1 exactly in `LOCKED`.

## Timing
- Reset values: `code=0`, `buttons=0`, `locked=0`, `frame_stb=0`. Synchronizer flops, window, `cand`, counters reset to 0; FSM resets to `HUNT`.
- Latency: input edge → synchronized edge detected is 2–3 clk. `code`, `buttons`, `locked` and `frame_stb` are all registered, valid 1 clk after the LSB strobe of the accepting frame.
- Fastest lock: `LOCK_FRAMES`×8 bit times after the first full header is sampled.
- Timing tolerance: ±(`BIT_CYCLES/2`−3) cycles of accumulated drift between edges; the header guarantees at least 3 edges per frame.
- Reset asserted mid-frame: all outputs clear asynchronously; reacquisition starts from `HUNT` after release.

## Configuration
- `CODE_RX_TIMEOUT_EN` defined:
  - An idle counter clears on every detected edge.
  - If no edge occurs for 16 bit times (16×`BIT_CYCLES` cycles), FSM goes to `HUNT`, `locked<=0`, `buttons<=0`.
- Not defined: no idle counter. A stuck line is detected only by a header mismatch at the next frame check.

## Structure
- Package `code_link_pkg`:
  - `CODE_W=8`, `KEY_W=4`, `HEADER=4'b1010`, `DEF_BIT_CYCLES=12500`.
  - FSM state enum `rx_state_t`.
  - Shared with the TX encoder.
- Sub-module `bit_sampler`: synchronizer, edge detect, phase counter. Outputs `bit_val` and `bit_stb`. FSM, window and output registers live in `code_receiver`.

## Test plan
Bench uses `BIT_CYCLES=16`, `LOCK_FRAMES=2`.
- Continuous frames `8'hA5`, reset released → `locked` rises 1 clk after the LSB strobe of the 2nd checked frame; `code=8'hA5`, `buttons=4'b0101`, `frame_stb` once per 128 clk thereafter.
- While locked, switch to `8'hA3` → `buttons=4'b0011` 1 clk after that frame's LSB strobe; `locked` stays 1.
- Inject one frame `8'hE5` → `locked=0` and `buttons=0` at its check; relock after 2 good frames; `code` held `8'hA5` meanwhile.
- Stream begins at bit 3 of a frame, and bit period alternates 15/17 clk → lock only on true alignment, never on a shifted header, and lock is held throughout.
- Assert `rst_n` mid-`LOCKED` → all outputs 0 within the same cycle; relock after release.
- With `CODE_RX_TIMEOUT_EN`, hold `serial_in=1` for 16×16 clk while locked → `locked=0`, `buttons=0`. Without the macro → unlock at the next frame check.
